// File: rtl/oserdes_tx_sequencer.sv
// oserdes_tx_sequencer: OSERDESE2 lane reset/warm-up/stream sequencer in the CLKDIV domain
// Optional saturating underflow counter enabled by defining OSERDES_TX_UNDERFLOW_CNT_EN
module oserdes_tx_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int RESET_CYCLES = 4,
  parameter int WARMUP_CYCLES = 2,
  parameter logic [7:0] IDLE_PATTERN = 8'h00
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  en,
  input  logic                  resync,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] d_out,
  output logic                  oserdes_rst,
  output logic                  oce,
  output logic                  tce,
  output logic                  t_out,
  output logic                  link_up,
  output logic [15:0]           underflow_count
);
  localparam int MAXC = RESET_CYCLES > WARMUP_CYCLES ? RESET_CYCLES : WARMUP_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] RST_LAST = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] WU_LAST = CW'(WARMUP_CYCLES - 1);
  localparam logic [DATA_WIDTH-1:0] IDLE = IDLE_PATTERN[DATA_WIDTH-1:0];
  typedef enum logic [1:0] {RESET_HOLD, WARMUP, ACTIVE, PARKED} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] count, count_nxt;
  logic transfer;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= RESET_HOLD;
      count <= '0;
      d_out <= IDLE;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      d_out <= transfer ? in_data : IDLE;
    end
  end
  // count only advances in the timed states; it is zero on entry to each of them
  always_comb begin
    state_nxt = state;
    count_nxt = '0;
    if (resync) state_nxt = RESET_HOLD;
    else if (state == RESET_HOLD) begin
      state_nxt = count == RST_LAST ? WARMUP : RESET_HOLD;
      count_nxt = count == RST_LAST ? '0 : count + CW'(1);
    end else if (state == WARMUP) begin
      state_nxt = count == WU_LAST ? (en ? ACTIVE : PARKED) : WARMUP;
      count_nxt = count == WU_LAST ? '0 : count + CW'(1);
    end else state_nxt = en ? ACTIVE : PARKED;
  end
  assign oserdes_rst = state == RESET_HOLD;
  assign oce = state != RESET_HOLD;
  assign tce = state != RESET_HOLD;
  assign t_out = state != ACTIVE;
  assign link_up = state == ACTIVE;
  assign in_ready = link_up & en & ~resync;
  assign transfer = in_valid & in_ready;
`ifdef OSERDES_TX_UNDERFLOW_CNT_EN
  always_ff @(posedge CLK) begin
    if (RST || resync) underflow_count <= '0;
    else if (link_up && en && !in_valid && underflow_count != 16'hFFFF)
      underflow_count <= underflow_count + 16'd1;
  end
`else
  assign underflow_count = 16'h0000;
`endif
endmodule
